// File: rtl/ysyx_22041752_multer.sv
// Iterative shift-add multiplier producing the full 2*WIDTH-bit product for RV64M.
// Define YSYX_22041752_MUL_FAST_EN to replace the FSM with a zero-latency combinational multiply.
module ysyx_22041752_multer #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    input  logic             mul_valid,
    input  logic [1:0]       mul_signed,
    output logic             out_valid,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi
);

    logic a_s;
    logic b_s;

    assign a_s = mul_signed[1] & multiplicand[WIDTH-1];
    assign b_s = mul_signed[0] & multiplier[WIDTH-1];

`ifdef YSYX_22041752_MUL_FAST_EN

    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] prod;

    assign a_ext     = {{WIDTH{a_s}}, multiplicand};
    assign b_ext     = {{WIDTH{b_s}}, multiplier};
    assign prod      = a_ext * b_ext;
    assign out_valid = mul_valid;
    assign result_lo = prod[WIDTH-1:0];
    assign result_hi = prod[2*WIDTH-1:WIDTH];

`else

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    count_q, count_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic               p_s_q, p_s_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_lo_q, result_lo_d;
    logic [WIDTH-1:0]   result_hi_q, result_hi_d;

    logic               p_s;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;

    assign p_s   = a_s ^ b_s;
    assign a_mag = a_s ? (~multiplicand + WIDTH'(1)) : multiplicand;
    assign b_mag = b_s ? (~multiplier + WIDTH'(1)) : multiplier;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        p_s_d       = p_s_q;
        out_valid_d = 1'b0;
        result_lo_d = result_lo_q;
        result_hi_d = result_hi_q;
        sum         = '0;
        prod        = '0;

        if (flush) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (mul_valid) begin
                        p_s_d   = p_s;
                        count_d = '0;
                        if (multiplicand == '0 || multiplier == '0) begin
                            state_d     = StDone;
                            out_valid_d = 1'b1;
                            result_lo_d = '0;
                            result_hi_d = '0;
                        end else begin
                            state_d = StBusy;
                            acc_d   = {{WIDTH{1'b0}}, b_mag};
                            mcand_d = a_mag;
                        end
                    end
                end
                StBusy: begin
                    if (!mul_valid) begin
                        state_d = StIdle;
                    end else begin
                        sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                                + {1'b0, (acc_q[0] ? mcand_q : {WIDTH{1'b0}})};
                        acc_d   = {sum, acc_q[WIDTH-1:1]};
                        count_d = count_q + CntW'(1);
                        if (count_q == CntW'(WIDTH - 1)) begin
                            // Results are captured on DONE entry from the final accumulator.
                            state_d     = StDone;
                            out_valid_d = 1'b1;
                            prod        = p_s_q ? (~acc_d + (2*WIDTH)'(1)) : acc_d;
                            result_lo_d = prod[WIDTH-1:0];
                            result_hi_d = prod[2*WIDTH-1:WIDTH];
                        end
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            count_q     <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            p_s_q       <= 1'b0;
            out_valid_q <= 1'b0;
            result_lo_q <= '0;
            result_hi_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            p_s_q       <= p_s_d;
            out_valid_q <= out_valid_d;
            result_lo_q <= result_lo_d;
            result_hi_q <= result_hi_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result_lo = result_lo_q;
    assign result_hi = result_hi_q;

`endif

endmodule

// File: tb/tb_ysyx_22041752_multer.sv
// Directed self-checking bench for the iterative multiplier (default build).
module tb_ysyx_22041752_multer;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [63:0] multiplicand;
    logic [63:0] multiplier;
    logic        mul_valid;
    logic [1:0]  mul_signed;
    logic        out_valid;
    logic [63:0] result_lo;
    logic [63:0] result_hi;

    int n_checks = 0;
    int n_errors = 0;

    ysyx_22041752_multer #(.WIDTH(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .mul_valid    (mul_valid),
        .mul_signed   (mul_signed),
        .out_valid    (out_valid),
        .result_lo    (result_lo),
        .result_hi    (result_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request, wait (bounded) for out_valid, then check latency, result and pulse width.
    task automatic run_op(input string tag, input logic [1:0] s, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp_hi,
                          input logic [63:0] exp_lo, input int exp_lat);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        mul_signed   = s;
        multiplicand = a;
        multiplier   = b;
        mul_valid    = 1'b1;
        while (!seen && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid) seen = 1'b1;
        end
        check_eq({tag, "_lat"}, 128'(n), 128'(exp_lat));
        check_eq({tag, "_hi"}, {64'd0, result_hi}, {64'd0, exp_hi});
        check_eq({tag, "_lo"}, {64'd0, result_lo}, {64'd0, exp_lo});
        mul_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq({tag, "_pulse"}, {127'd0, out_valid}, 128'd0);
    endtask

    // Start a request, run it for `cycles` edges, and report whether out_valid appeared.
    task automatic start_and_wait(input logic [63:0] a, input logic [63:0] b, input int cycles,
                                  output bit seen);
        seen         = 1'b0;
        mul_signed   = 2'b00;
        multiplicand = a;
        multiplier   = b;
        mul_valid    = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
    endtask

    task automatic idle_watch(input int cycles, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
    endtask

    initial begin
        bit seen_a;
        bit seen_b;

        reset        = 1'b1;
        flush        = 1'b0;
        mul_valid    = 1'b0;
        mul_signed   = 2'b00;
        multiplicand = '0;
        multiplier   = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", {127'd0, out_valid}, 128'd0);
        check_eq("rst_lo", {64'd0, result_lo}, 128'd0);
        check_eq("rst_hi", {64'd0, result_hi}, 128'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_op("u3x5", 2'b00, 64'd3, 64'd5, 64'd0, 64'd15, 65);
        run_op("s_m1xm1", 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'd0, 64'd1, 65);
        run_op("s_minxm1", 2'b11, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'd0, 64'h8000_0000_0000_0000, 65);
        run_op("su_m1xmax", 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 65);
        run_op("u_maxxmax", 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65);
        run_op("s_m3x5", 2'b11, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF1, 65);
        run_op("us_7xm2", 2'b01, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF2, 65);
        run_op("u_2p63x4", 2'b00, 64'h8000_0000_0000_0000, 64'd4, 64'd2, 64'd0, 65);
        run_op("zero_a", 2'b00, 64'd0, 64'h1234, 64'd0, 64'd0, 1);
        run_op("after_zero", 2'b00, 64'd9, 64'd11, 64'd0, 64'd99, 65);
        run_op("zero_b", 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 64'd0, 1);
        run_op("u3x5_b", 2'b00, 64'd3, 64'd5, 64'd0, 64'd15, 65);

        // Flush mid-operation: no pulse, previous result (15) retained.
        start_and_wait(64'd1000, 64'd1000, 30, seen_a);
        flush     = 1'b1;
        mul_valid = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b0;
        idle_watch(80, seen_b);
        check_eq("flush_novalid", {127'd0, seen_a | seen_b}, 128'd0);
        check_eq("flush_hold_lo", {64'd0, result_lo}, 128'd15);
        run_op("flush_7x6", 2'b00, 64'd7, 64'd6, 64'd0, 64'd42, 65);

        // Reset mid-operation: outputs cleared.
        start_and_wait(64'd1000, 64'd1000, 40, seen_a);
        reset     = 1'b1;
        mul_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("rst_mid_novalid", {127'd0, seen_a | out_valid}, 128'd0);
        check_eq("rst_mid_lo", {64'd0, result_lo}, 128'd0);
        check_eq("rst_mid_hi", {64'd0, result_hi}, 128'd0);
        run_op("rst_7x6", 2'b00, 64'd7, 64'd6, 64'd0, 64'd42, 65);

        // Dropping mul_valid while busy aborts silently.
        start_and_wait(64'd1000, 64'd1000, 20, seen_a);
        mul_valid = 1'b0;
        idle_watch(80, seen_b);
        check_eq("abort_novalid", {127'd0, seen_a | seen_b}, 128'd0);
        check_eq("abort_hold_lo", {64'd0, result_lo}, 128'd42);
        run_op("abort_7x6", 2'b00, 64'd7, 64'd6, 64'd0, 64'd42, 65);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
